ice_status_led: RTL and testbench



---
 rtl/ice_status_pkg.sv | 19 +
 rtl/ice_led_stretch.sv | 39 +++
 rtl/ice_status_led.sv | 180 ++++++++++++++++++
 tb/tb_ice_status_led.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ice_status_pkg.sv
// Shared types and widths for the ICE pod status-LED driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum (LAMP, NORMAL) and counter widths for the
// prescaler, stretch, clock-window and lamp-test counters.
package ice_status_pkg;

    typedef enum logic {
        LAMP,
        NORMAL
    } state_t;

    localparam int PRESC_W   = 15;
    localparam int STRETCH_W = 6;
    localparam int WIN_W     = 4;
    localparam int LAMP_W    = 9;

endpackage

// File: rtl/ice_led_stretch.sv
// Pulse stretcher: keeps a short event visible for STRETCH_MS ticks after it falls.
// Latency: active is combinational from ev; the hold-off counter updates each clk.
// Backpressure: none; ev is sampled every cycle.
//
// Ports:
//   clk     system clock
//   reset   synchronous active-high reset, clears the hold-off counter
//   tick    1 ms tick strobe from the prescaler
//   ev      event level to stretch
//   active  ev high or hold-off counter nonzero
module ice_led_stretch
    import ice_status_pkg::*;
#(
    parameter int STRETCH_MS = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic ev,
    output logic active
);

    logic [STRETCH_W-1:0] cnt;

    // Reload wins over a coincident tick, so a re-asserted event never
    // leaves a dark gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (ev) begin
            cnt <= STRETCH_W'(STRETCH_MS);
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - STRETCH_W'(1);
        end
    end

    assign active = ev | (cnt != '0);

endmodule

// File: rtl/ice_status_led.sv
// Status-LED driver for the K0R IECUBE ICE pod: stretched events, clock detect, lamp test.
// Latency: level inputs reach the registered LED/ETVDDSEL outputs in 1 cycle.
// Backpressure: none; all inputs are sampled every cycle.
//
// Ports: CLK30MHZ_GB clock, ICERES sync active-high reset; TVDDON, TVDDSEL,
// CPURUN, CPUSTBY, CPURES, WAITOR status levels; TCLKTGL async target-clock
// toggle; ETVDDSEL registered TVDDSEL; ELED*_B active-low LED drives.
// Build option: define ICE_LED_LAMPTEST_EN to light every LED for
// LAMPTEST_MS ticks after reset; otherwise NORMAL is entered directly.
module ice_status_led
    import ice_status_pkg::*;
#(
    parameter int PRESC_DIV   = 30000,
    parameter int STRETCH_MS  = 50,
    parameter int CLKWIN_MS   = 4,
    parameter int LAMPTEST_MS = 500
) (
    input  logic CLK30MHZ_GB,
    input  logic ICERES,
    input  logic TVDDON,
    input  logic TVDDSEL,
    input  logic CPURUN,
    input  logic CPUSTBY,
    input  logic CPURES,
    input  logic WAITOR,
    input  logic TCLKTGL,
    output logic ETVDDSEL,
    output logic ELEDTVDD_B,
    output logic ELEDCLOCK_B,
    output logic ELEDRUN_B,
    output logic ELEDRESET_B,
    output logic ELEDSTANDBY_B,
    output logic ELEDWAIT_B
);

    // ---------------- 1 ms prescaler ----------------
    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;

    assign tick = (presc_cnt == PRESC_W'(PRESC_DIV - 1));

    always_ff @(posedge CLK30MHZ_GB) begin
        if (ICERES || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    // ---------------- lamp test / FSM ----------------
    state_t state_q;
    state_t state_d;
    logic   lamp_last;

`ifdef ICE_LED_LAMPTEST_EN
    localparam state_t RESET_STATE = LAMP;

    logic [LAMP_W-1:0] lamp_cnt;

    assign lamp_last = tick && (lamp_cnt == LAMP_W'(LAMPTEST_MS - 1));

    always_ff @(posedge CLK30MHZ_GB) begin
        if (ICERES) begin
            lamp_cnt <= '0;
        end else if ((state_q == LAMP) && tick) begin
            lamp_cnt <= lamp_cnt + LAMP_W'(1);
        end
    end
`else
    localparam state_t RESET_STATE = NORMAL;

    // LAMP is unreachable in this build; the expression is constant false
    // for every legal duration and keeps the parameter tied into the design.
    assign lamp_last = (LAMPTEST_MS >= (1 << LAMP_W));
`endif

    always_ff @(posedge CLK30MHZ_GB) begin
        if (ICERES) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LAMP:    if (lamp_last) state_d = NORMAL;
            default: state_d = state_q;
        endcase
    end

    // ---------------- stretch channels ----------------
    logic wait_active;
    logic reset_active;

    ice_led_stretch #(.STRETCH_MS(STRETCH_MS)) u_stretch_wait (
        .clk    (CLK30MHZ_GB),
        .reset  (ICERES),
        .tick   (tick),
        .ev     (WAITOR),
        .active (wait_active)
    );

    ice_led_stretch #(.STRETCH_MS(STRETCH_MS)) u_stretch_reset (
        .clk    (CLK30MHZ_GB),
        .reset  (ICERES),
        .tick   (tick),
        .ev     (CPURES),
        .active (reset_active)
    );

    // ---------------- target clock detect ----------------
    logic             tclk_s1, tclk_s2, tclk_s3;
    logic             tclk_edge;
    logic             seen;
    logic             clk_ok;
    logic [WIN_W-1:0] win_cnt;
    logic             win_close;

    assign tclk_edge = tclk_s2 ^ tclk_s3;
    assign win_close = tick && (win_cnt == WIN_W'(CLKWIN_MS - 1));

    always_ff @(posedge CLK30MHZ_GB) begin
        if (ICERES) begin
            tclk_s1 <= 1'b0;
            tclk_s2 <= 1'b0;
            tclk_s3 <= 1'b0;
            seen    <= 1'b0;
            clk_ok  <= 1'b0;
            win_cnt <= '0;
        end else begin
            tclk_s1 <= TCLKTGL;
            tclk_s2 <= tclk_s1;
            tclk_s3 <= tclk_s2;
            if (tick) begin
                win_cnt <= win_close ? '0 : win_cnt + WIN_W'(1);
            end
            // An edge landing in the closing cycle belongs to the closing
            // window only; the next window starts clean.
            if (win_close) begin
                clk_ok <= seen | tclk_edge;
                seen   <= 1'b0;
            end else if (tclk_edge) begin
                seen <= 1'b1;
            end
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge CLK30MHZ_GB) begin
        if (ICERES) begin
            ETVDDSEL      <= 1'b0;
            ELEDTVDD_B    <= 1'b1;
            ELEDCLOCK_B   <= 1'b1;
            ELEDRUN_B     <= 1'b1;
            ELEDRESET_B   <= 1'b1;
            ELEDSTANDBY_B <= 1'b1;
            ELEDWAIT_B    <= 1'b1;
        end else begin
            ETVDDSEL <= TVDDSEL;
            if (state_q == LAMP) begin
                ELEDTVDD_B    <= 1'b0;
                ELEDCLOCK_B   <= 1'b0;
                ELEDRUN_B     <= 1'b0;
                ELEDRESET_B   <= 1'b0;
                ELEDSTANDBY_B <= 1'b0;
                ELEDWAIT_B    <= 1'b0;
            end else begin
                ELEDTVDD_B    <= ~TVDDON;
                ELEDCLOCK_B   <= ~clk_ok;
                ELEDRUN_B     <= ~(CPURUN & ~CPURES);
                ELEDRESET_B   <= ~reset_active;
                ELEDSTANDBY_B <= ~(CPUSTBY & ~CPURES & ~CPURUN);
                ELEDWAIT_B    <= ~wait_active;
            end
        end
    end

endmodule

// File: tb/tb_ice_status_led.sv
// Self-checking bench for ice_status_led with a closed-form reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ice_status_led;

    localparam int P    = 4;   // PRESC_DIV
    localparam int S    = 3;   // STRETCH_MS
    localparam int W    = 2;   // CLKWIN_MS
    localparam int L    = 5;   // LAMPTEST_MS
    localparam int MAXC = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic iceres, tvddon, tvddsel, cpurun, cpustby, cpures, waitor, tclktgl;
    logic etvddsel, led_tvdd, led_clock, led_run, led_reset, led_stby, led_wait;
    logic [6:0] dut_vec;

    assign dut_vec = {etvddsel, led_tvdd, led_clock, led_run, led_reset, led_stby, led_wait};

    ice_status_led #(
        .PRESC_DIV   (P),
        .STRETCH_MS  (S),
        .CLKWIN_MS   (W),
        .LAMPTEST_MS (L)
    ) dut (
        .CLK30MHZ_GB   (clk),
        .ICERES        (iceres),
        .TVDDON        (tvddon),
        .TVDDSEL       (tvddsel),
        .CPURUN        (cpurun),
        .CPUSTBY       (cpustby),
        .CPURES        (cpures),
        .WAITOR        (waitor),
        .TCLKTGL       (tclktgl),
        .ETVDDSEL      (etvddsel),
        .ELEDTVDD_B    (led_tvdd),
        .ELEDCLOCK_B   (led_clock),
        .ELEDRUN_B     (led_run),
        .ELEDRESET_B   (led_reset),
        .ELEDSTANDBY_B (led_stby),
        .ELEDWAIT_B    (led_wait)
    );

    // Input vector layout: [6]TVDDON [5]TVDDSEL [4]CPURUN [3]CPUSTBY
    // [2]CPURES [1]WAITOR [0]TCLKTGL. hist[k] is the vector sampled at
    // edge k after reset release (edge 1 is the first non-reset edge).
    logic [6:0] hist [0:MAXC-1];
    logic [6:0] cur;
    int         n;
    int         checks = 0;
    int         passed = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step(input logic rst, input logic [6:0] v);
        @(negedge clk);
        iceres = rst;
        cur    = v;
        {tvddon, tvddsel, cpurun, cpustby, cpures, waitor, tclktgl} = v;
        @(posedge clk);
        if (rst) begin
            n = 0;
        end else begin
            if (n >= MAXC - 1) begin
                $display("FAIL history_overflow n=%0d limit=%0d", n, MAXC - 1);
                $fatal(1);
            end
            n++;
            hist[n] = v;
        end
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic tsig(int k);
        return (k >= 1) ? hist[k][0] : 1'b0;
    endfunction

    // Stretch rule: on while the event is high; after it falls, on until
    // S ticks have passed. Ticks fall on edges that are multiples of P.
    function automatic logic stretched(int k, int b);
        int last;
        last = -1;
        if (hist[k][b]) return 1'b1;
        for (int j = k - 1; j >= 1; j--) begin
            if (hist[j][b]) begin
                last = j;
                break;
            end
        end
        if (last < 0) return 1'b0;
        return (((k - 1) / P) - (last / P)) < S;
    endfunction

    // Window closes on edges that are multiples of P*W; clk_ok reflects
    // any synchronised toggle seen inside the last fully closed window.
    function automatic logic clk_ok_at(int k);
        int  c;
        logic ok;
        c  = ((k - 1) / (P * W)) * (P * W);
        ok = 1'b0;
        if (c < P * W) return 1'b0;
        for (int m = c - P * W + 1; m <= c; m++) ok = ok | (tsig(m - 2) ^ tsig(m - 3));
        return ok;
    endfunction

    function automatic logic [6:0] model(int k);
        logic [6:0] v;
        logic       lamp;
        v = hist[k];
`ifdef ICE_LED_LAMPTEST_EN
        lamp = (k <= L * P);
`else
        lamp = 1'b0;
`endif
        if (lamp) return {v[5], 6'b000000};
        return {v[5], ~v[6], ~clk_ok_at(k), ~(v[4] & ~v[2]), ~stretched(k, 2),
                ~(v[3] & ~v[2] & ~v[4]), ~stretched(k, 1)};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 7'($urandom));
            checks++;
            if (dut_vec !== 7'b0111111)
                $display("FAIL reset_values cycle=%0d got=%b exp=%b", i, dut_vec, 7'b0111111);
            else passed++;
        end
    endtask

    task automatic test_lamp();
        logic [6:0] e;
        for (int i = 0; i < 26; i++) begin
            step(1'b0, 7'b0000000);
            e = model(n);
            checks++;
            if (dut_vec !== e) $display("FAIL lamp n=%0d got=%b exp=%b", n, dut_vec, e);
            else passed++;
`ifdef ICE_LED_LAMPTEST_EN
            if (n == 20 || n == 21) begin
                checks++;
                if (dut_vec[5:0] !== ((n == 21) ? 6'h3f : 6'h00))
                    $display("FAIL lamp_boundary n=%0d got=%b", n, dut_vec[5:0]);
                else passed++;
            end
`endif
        end
    endtask

    task automatic test_run_standby();
        logic [6:0] e;
        step(1'b0, 7'b1111000);
        checks++;
        if ({etvddsel, led_tvdd, led_run, led_stby} !== 4'b1001)
            $display("FAIL run_over_stby got=%b exp=%b", {etvddsel, led_tvdd, led_run, led_stby}, 4'b1001);
        else passed++;
        step(1'b0, 7'b1111100);
        checks++;
        if ({led_run, led_reset, led_stby} !== 3'b101)
            $display("FAIL cpures_mask got=%b exp=%b", {led_run, led_reset, led_stby}, 3'b101);
        else passed++;
        step(1'b0, 7'b0001000);
        checks++;
        if ({etvddsel, led_tvdd, led_run, led_reset, led_stby} !== 5'b01100)
            $display("FAIL stby_only got=%b exp=%b", {etvddsel, led_tvdd, led_run, led_reset, led_stby}, 5'b01100);
        else passed++;
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 7'b0000000);
            e = model(n);
            checks++;
            if (dut_vec !== e) $display("FAIL run_stby_drain n=%0d got=%b exp=%b", n, dut_vec, e);
            else passed++;
        end
    endtask

    task automatic test_wait_stretch();
        logic [6:0] e;
        int p, rise;
        step(1'b0, 7'b0000010);
        p = n;
        checks++;
        if (led_wait !== 1'b0) $display("FAIL wait_on got=%b exp=0", led_wait);
        else passed++;
        rise = -1;
        for (int i = 0; i < 30 && rise < 0; i++) begin
            step(1'b0, 7'b0000000);
            e = model(n);
            checks++;
            if (dut_vec !== e) $display("FAIL wait_stretch n=%0d got=%b exp=%b", n, dut_vec, e);
            else passed++;
            if (led_wait === 1'b1) rise = n;
        end
        checks++;
        if (rise < 0 || (rise - (p + 1)) < 9 || (rise - (p + 1)) > 13)
            $display("FAIL wait_release delay=%0d required=9..13", (rise < 0) ? -1 : rise - (p + 1));
        else passed++;
        // Re-assert mid-stretch: the LED must stay on without a gap.
        step(1'b0, 7'b0000010);
        for (int i = 0; i < 6; i++) step(1'b0, 7'b0000000);
        step(1'b0, 7'b0000010);
        checks++;
        if (led_wait !== 1'b0) $display("FAIL wait_reload got=%b exp=0", led_wait);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 7'b0000000);
            e = model(n);
            checks++;
            if (dut_vec !== e) $display("FAIL wait_reload_tail n=%0d got=%b exp=%b", n, dut_vec, e);
            else passed++;
        end
    endtask

    task automatic test_clock_detect();
        logic [6:0] e;
        logic t;
        int first_low, first_high;
        t = 1'b0;
        first_low = -1;
        for (int i = 0; i < 48; i++) begin
            if (i % 3 == 0) t = ~t;
            step(1'b0, {6'b100000, t});
            e = model(n);
            checks++;
            if (dut_vec !== e) $display("FAIL clk_toggle n=%0d got=%b exp=%b", n, dut_vec, e);
            else passed++;
            if (led_clock === 1'b0 && first_low < 0) first_low = i;
        end
        checks++;
        if (first_low < 0 || first_low >= 16)
            $display("FAIL clk_detect_on cycles=%0d required=<16", first_low);
        else passed++;
        first_high = -1;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, {6'b100000, t});
            e = model(n);
            checks++;
            if (dut_vec !== e) $display("FAIL clk_stop n=%0d got=%b exp=%b", n, dut_vec, e);
            else passed++;
            if (led_clock === 1'b1 && first_high < 0) first_high = i;
        end
        checks++;
        if (first_high < 0 || first_high >= 16)
            $display("FAIL clk_detect_off cycles=%0d required=<16", first_high);
        else passed++;
    endtask

    task automatic test_random();
        logic [6:0] v, e;
        v = cur;
        for (int i = 0; i < 300; i++) begin
            for (int b = 2; b <= 6; b++) if ($urandom_range(15) == 0) v[b] = ~v[b];
            v[1] = ($urandom_range(11) == 0);
            if (i < 150 && $urandom_range(3) == 0) v[0] = ~v[0];
            step(1'b0, v);
            e = model(n);
            checks++;
            if (dut_vec !== e) $display("FAIL random n=%0d in=%b got=%b exp=%b", n, v, dut_vec, e);
            else passed++;
        end
    endtask

    task automatic test_reset_midop();
        logic [6:0] e;
        step(1'b0, 7'b1000010);
        step(1'b0, 7'b1000000);
        checks++;
        if (led_wait !== 1'b0) $display("FAIL midop_stretch_active got=%b exp=0", led_wait);
        else passed++;
        step(1'b1, 7'b1110000);
        checks++;
        if (dut_vec !== 7'b0111111)
            $display("FAIL midop_reset got=%b exp=%b", dut_vec, 7'b0111111);
        else passed++;
        for (int i = 0; i < 26; i++) begin
            step(1'b0, 7'b1010000);
            e = model(n);
            checks++;
            if (dut_vec !== e) $display("FAIL midop_restart n=%0d got=%b exp=%b", n, dut_vec, e);
            else passed++;
        end
    endtask

    initial begin
        iceres = 1'b1;
        {tvddon, tvddsel, cpurun, cpustby, cpures, waitor, tclktgl} = 7'b0;
        cur = 7'b0;
        n   = 0;
        test_reset();
        test_lamp();
        test_run_standby();
        test_wait_stretch();
        test_clock_detect();
        test_random();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
